// File: rtl/draw_pkg.sv
// Shared types and constants for the drawing-engine scheduler.
//   sched_state_t : scheduler FSM state encoding
//   SCREEN_W/H    : visible raster size; pixels outside it are never plotted
//   N_CLIENTS     : number of drawing engines sequenced
//   PLOT_CNT_W    : width of the forwarded-pixel counter
package draw_pkg;

    localparam int N_CLIENTS  = 3;
    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int PLOT_CNT_W = 15;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int IDX_W    = 2;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        WAIT_DONE,
        RELEASE,
        FINISH
    } sched_state_t;

    function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/plot_mux.sv
// Registered pixel multiplexer with screen-bounds check.
//   clk, rst_n        : clock, async active-low reset
//   sel               : index of the client whose pixel bus is forwarded
//   active            : forward only while high; otherwise vga_plot is forced low
//   cl_x/y/colour/plot: per-client pixel buses
//   vga_x/y/colour/plot: registered copy of the selected client's pixel
module plot_mux
    import draw_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [IDX_W-1:0]                     sel,
    input  logic                                 active,
    input  logic [N_CLIENTS-1:0][X_W-1:0]        cl_x,
    input  logic [N_CLIENTS-1:0][Y_W-1:0]        cl_y,
    input  logic [N_CLIENTS-1:0][COLOUR_W-1:0]   cl_colour,
    input  logic [N_CLIENTS-1:0]                 cl_plot,
    output logic [X_W-1:0]                       vga_x,
    output logic [Y_W-1:0]                       vga_y,
    output logic [COLOUR_W-1:0]                  vga_colour,
    output logic                                 vga_plot
);

    logic [X_W-1:0]      w_x;
    logic [Y_W-1:0]      w_y;
    logic [COLOUR_W-1:0] w_colour;
    logic                w_plot;

    logic [X_W-1:0]      r_vga_x;
    logic [Y_W-1:0]      r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;
    logic                r_vga_plot;

    assign w_x      = cl_x[sel];
    assign w_y      = cl_y[sel];
    assign w_colour = cl_colour[sel];
    // Off-screen pixels still pass their coordinates through, but never plot.
    assign w_plot   = cl_plot[sel] & in_bounds(w_x, w_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else if (active) begin
            r_vga_x      <= w_x;
            r_vga_y      <= w_y;
            r_vga_colour <= w_colour;
            r_vga_plot   <= w_plot;
        end else begin
            r_vga_plot   <= 1'b0;
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;

endmodule

// File: rtl/plot_scheduler.sv
// Sequences up to three drawing engines in order 0,1,2 using a level
// start/done handshake, forwarding the active engine's pixels to the VGA port.
//   clk, rst_n   : clock, async active-low reset
//   start, done  : sequence request / completion (done held until start drops)
//   enable       : per-client run mask, sampled when a sequence begins
//   cl_start/cl_done : per-client handshake
//   cl_x/y/colour/plot : per-client pixel buses
//   vga_*        : forwarded pixel, one cycle latency
//   plot_count   : pixels plotted in the current or last sequence (saturating)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; plot_count holds last value
// SELECT    | test en_q[idx]; skip disabled clients one per cycle
// LAUNCH    | first cycle of cl_start[idx]
// WAIT_DONE | hold cl_start[idx] until cl_done[idx]
// RELEASE   | start dropped, wait for cl_done[idx] to fall
// FINISH    | done=1 until start drops
module plot_scheduler #(
    parameter int N_CLIENTS = draw_pkg::N_CLIENTS
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic [N_CLIENTS-1:0]                          enable,
    output logic                                          done,
    output logic [N_CLIENTS-1:0]                          cl_start,
    input  logic [N_CLIENTS-1:0]                          cl_done,
    input  logic [N_CLIENTS-1:0][draw_pkg::X_W-1:0]       cl_x,
    input  logic [N_CLIENTS-1:0][draw_pkg::Y_W-1:0]       cl_y,
    input  logic [N_CLIENTS-1:0][draw_pkg::COLOUR_W-1:0]  cl_colour,
    input  logic [N_CLIENTS-1:0]                          cl_plot,
    output logic [draw_pkg::X_W-1:0]                      vga_x,
    output logic [draw_pkg::Y_W-1:0]                      vga_y,
    output logic [draw_pkg::COLOUR_W-1:0]                 vga_colour,
    output logic                                          vga_plot,
    output logic [draw_pkg::PLOT_CNT_W-1:0]               plot_count
);
    import draw_pkg::*;

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [N_CLIENTS-1:0]  r_en_q;
    logic [PLOT_CNT_W-1:0] r_plot_count;
    logic                  w_latch;
    logic                  w_idx_inc;
    logic                  w_last;
    logic                  w_active;

    assign w_last   = (r_idx == IDX_W'(N_CLIENTS - 1));
    assign w_active = (r_state == LAUNCH) || (r_state == WAIT_DONE) || (r_state == RELEASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_idx_inc   = 1'b0;
        cl_start    = '0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (r_en_q[r_idx]) begin
                    w_state_nxt = LAUNCH;
                end else if (w_last) begin
                    w_state_nxt = FINISH;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            LAUNCH: begin
                cl_start[r_idx] = 1'b1;
                w_state_nxt     = WAIT_DONE;
            end
            WAIT_DONE: begin
                cl_start[r_idx] = 1'b1;
                if (cl_done[r_idx]) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!cl_done[r_idx]) begin
                    if (w_last) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_idx_inc   = 1'b1;
                        w_state_nxt = SELECT;
                    end
                end
            end
            FINISH: begin
                done = 1'b1;
                if (!start) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_en_q <= '0;
        end else if (w_latch) begin
            r_idx  <= '0;
            r_en_q <= enable;
        end else if (w_idx_inc) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    // Counts registered plots, so it trails vga_plot by one cycle; the
    // handshake always leaves at least that much slack before FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plot_count <= '0;
        end else if (w_latch) begin
            r_plot_count <= '0;
        end else if (vga_plot && (r_plot_count != '1)) begin
            r_plot_count <= r_plot_count + 1'b1;
        end
    end

    assign plot_count = r_plot_count;

    plot_mux u_plot_mux (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (r_idx),
        .active     (w_active),
        .cl_x       (cl_x),
        .cl_y       (cl_y),
        .cl_colour  (cl_colour),
        .cl_plot    (cl_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

endmodule

// File: tb/tb_plot_scheduler.sv
module tb_plot_scheduler;
    import draw_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       enable = '0;
    logic             done;
    logic [2:0]       cl_start;
    logic [2:0]       cl_done = '0;
    logic [2:0][7:0]  cl_x = '0;
    logic [2:0][6:0]  cl_y = '0;
    logic [2:0][2:0]  cl_colour = '0;
    logic [2:0]       cl_plot = '0;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             vga_plot;
    logic [14:0]      plot_count;

    plot_scheduler #(.N_CLIENTS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .done(done),
        .cl_start(cl_start), .cl_done(cl_done), .cl_x(cl_x), .cl_y(cl_y),
        .cl_colour(cl_colour), .cl_plot(cl_plot), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .plot_count(plot_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    typedef struct {
        logic [2:0] en;
        int         d0, d1, d2;
        int         np;
        logic [5:0] ord;
        int         n_ord;
        int         max_cyc;
    } vec_t;

    pix_t       pix_q[3][$];
    pix_t       exp_q[$];
    int         order_q[$];
    int         delay[3];
    int         wait_cnt[3];
    bit         seen[3];
    logic [2:0] tb_mask = '0;
    int         exp_count = 0;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Client models + scoreboard: compare last cycle's expectation, then drive.
    always @(negedge clk) begin
        pix_t p;
        pix_t e;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 3; i++) begin
                seen[i] = 0;
                wait_cnt[i] = 0;
                cl_done[i] = 1'b0;
                cl_plot[i] = 1'b0;
                pix_q[i].delete();
            end
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("vga_pixel", {13'd0, vga_x, vga_y, vga_colour, vga_plot}, {13'd0, e});
            end else begin
                chk("vga_plot_quiet", vga_plot, 1'b0);
            end
            chk("cl_start_onehot0", ($countones(cl_start) <= 1), 1);
            for (int i = 0; i < 3; i++) begin
                if (cl_start[i] && !seen[i]) begin
                    seen[i] = 1;
                    wait_cnt[i] = delay[i];
                    order_q.push_back(i);
                end
                if (cl_done[i] && !cl_start[i]) begin
                    cl_done[i] = 1'b0;
                    seen[i] = 0;
                end else if (seen[i] && !cl_done[i]) begin
                    if (wait_cnt[i] > 0) wait_cnt[i]--;
                    else if (pix_q[i].size() == 0) cl_done[i] = 1'b1;
                end
                if (!tb_mask[i]) begin
                    // never-selected clients spray in-range pixels that must be ignored
                    cl_plot[i]   = 1'b1;
                    cl_x[i]      = 8'($urandom_range(0, 159));
                    cl_y[i]      = 7'($urandom_range(0, 119));
                    cl_colour[i] = 3'($urandom);
                end else if (cl_start[i] && pix_q[i].size() > 0) begin
                    p = pix_q[i].pop_front();
                    cl_x[i]      = p.x;
                    cl_y[i]      = p.y;
                    cl_colour[i] = p.c;
                    cl_plot[i]   = p.p;
                    p.p = p.p && (p.x < 8'd160) && (p.y < 7'd120);
                    if (p.p) exp_count++;
                    exp_q.push_back(p);
                end else begin
                    cl_plot[i] = 1'b0;
                end
            end
        end
    end

    task automatic fill_rand(input int i, input int n);
        pix_t p;
        for (int k = 0; k < n; k++) begin
            p.x = 8'($urandom_range(0, 200));
            p.y = 7'($urandom_range(0, 127));
            p.c = 3'($urandom);
            p.p = ($urandom_range(0, 3) != 0);
            pix_q[i].push_back(p);
        end
    endtask

    task automatic run_seq(input logic [2:0] en, input logic [5:0] ord, input int n_ord,
                           input int max_cyc);
        int cyc;
        order_q.delete();
        exp_count = 0;
        tb_mask = en;
        @(negedge clk);
        start = 1'b1;
        enable = en;
        @(negedge clk);
        enable = ~en;
        cyc = 0;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_reached", done, 1'b1);
        chk("n_starts", order_q.size(), n_ord);
        for (int k = 0; k < n_ord && k < order_q.size(); k++)
            chk("client_order", order_q[k], 32'((ord >> (2 * k)) & 6'd3));
        chk("plot_count", plot_count, exp_count);
        repeat (3) @(negedge clk);
        chk("done_held", done, 1'b1);
        chk("cl_start_in_finish", cl_start, 3'b000);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", done, 1'b0);
        chk("plot_count_idle", plot_count, exp_count);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[6];
        pix_t p;
        int   cyc;

        vecs[0] = '{3'b111, 5, 3, 7, 4, {2'd2, 2'd1, 2'd0}, 3, 2000};
        vecs[1] = '{3'b101, 2, 2, 2, 6, {2'd0, 2'd2, 2'd0}, 2, 2000};
        vecs[2] = '{3'b000, 0, 0, 0, 0, 6'd0, 0, 5};
        vecs[3] = '{3'b010, 0, 0, 0, 3, 6'd1, 1, 2000};
        vecs[4] = '{3'b110, 1, 0, 4, 2, {2'd0, 2'd2, 2'd1}, 2, 2000};
        vecs[5] = '{3'b001, 0, 0, 0, 0, 6'd0, 1, 2000};

        repeat (3) @(negedge clk);
        chk("reset_done", done, 1'b0);
        chk("reset_cl_start", cl_start, 3'b000);
        chk("reset_vga", {13'd0, vga_x, vga_y, vga_colour, vga_plot}, 0);
        chk("reset_plot_count", plot_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[v]) begin
            delay[0] = vecs[v].d0;
            delay[1] = vecs[v].d1;
            delay[2] = vecs[v].d2;
            for (int i = 0; i < 3; i++)
                if (vecs[v].en[i]) fill_rand(i, vecs[v].np);
            run_seq(vecs[v].en, vecs[v].ord, vecs[v].n_ord, vecs[v].max_cyc);
        end

        // Bounds: first pixel off-screen (x=160), second on the last valid pixel.
        delay = '{0, 0, 0};
        p = '{x: 8'd160, y: 7'd5, c: 3'd1, p: 1'b1};
        pix_q[0].push_back(p);
        p = '{x: 8'd159, y: 7'd119, c: 3'd2, p: 1'b1};
        pix_q[0].push_back(p);
        run_seq(3'b001, 6'd0, 1, 100);
        chk("bounds_plot_count", plot_count, 1);

        // Reset in the middle of client 1's WAIT_DONE.
        delay = '{1, 40, 1};
        tb_mask = 3'b111;
        for (int i = 0; i < 3; i++) fill_rand(i, 2);
        @(negedge clk);
        start = 1'b1;
        enable = 3'b111;
        cyc = 0;
        while (!cl_start[1] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("client1_started", cl_start[1], 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_cl_start", cl_start, 3'b000);
        chk("rst_done", done, 1'b0);
        chk("rst_vga", {13'd0, vga_x, vga_y, vga_colour, vga_plot}, 0);
        chk("rst_plot_count", plot_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_cl_start", cl_start, 3'b000);
        chk("post_rst_done", done, 1'b0);
        delay = '{2, 2, 2};
        for (int i = 0; i < 3; i++) fill_rand(i, 3);
        run_seq(3'b111, {2'd2, 2'd1, 2'd0}, 3, 2000);

        // Full screen from client 0.
        delay = '{0, 0, 0};
        for (int k = 0; k < 19200; k++) begin
            p.x = 8'(k % 160);
            p.y = 7'(k / 160);
            p.c = 3'(k);
            p.p = 1'b1;
            pix_q[0].push_back(p);
        end
        run_seq(3'b001, 6'd0, 1, 25000);
        chk("full_screen_count", plot_count, 19200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
